mem_arbiter: RTL and testbench

Shares the single-port synchronous memory between two requesters: port 0 is the Processor, and port 1 is an I/O or loader master. Each port has a simple request/grant/read-valid handshake. The arbiter picks one transaction at a time and drives the registered memRead/memWrite/adrToMem/dataToMem strobes. Read data is routed back to the winning port. The block sits between the requesters and the memory model, replacing their direct connection.

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_pick.sv | 39 +++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// port index constants and a small helper that turns a port index into a
// one-hot grant/rvalid vector.
// Build option: MEM_ARB_RR_EN (round-robin when defined, fixed priority
// otherwise). It is consumed by mem_arb_pick and mem_arbiter.
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDATA  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_IO  = 1'b1;

    function automatic logic [1:0] port_onehot(input logic idx);
        return (idx == PORT_IO) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// ============================================================================
// mem_arb_pick
// Combinational winner selection for the memory arbiter.
// Build option: MEM_ARB_RR_EN
//   defined   : on a tie the port other than last_grant wins (round-robin)
//   undefined : on a tie port 0 (CPU) always wins; last_grant port absent
// Ports:
//   req        in  [1:0] per-port request
//   last_grant in        index of the previous winner (round-robin build only)
//   win        out       index of the selected port
//   win_valid  out       high when any port requests
// ============================================================================
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic       last_grant,
`endif
    output logic       win,
    output logic       win_valid
);

    // A lone requester always wins; only a tie needs the selection policy.
    always_comb begin
        win_valid = |req;
        win       = PORT_CPU;
        if (req == 2'b10) begin
            win = PORT_IO;
        end else if (req == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            win = ~last_grant;
`else
            win = PORT_CPU;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter
// Shares one single-port synchronous memory between the processor (port 0)
// and an I/O / loader master (port 1). One transaction per grant:
//   write: IDLE -> ACCESS -> IDLE          (2 cycles)
//   read : IDLE -> ACCESS -> RDATA -> IDLE (3 cycles)
// Build option: MEM_ARB_RR_EN (round-robin ties; fixed priority to port 0
// when undefined).
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   req[1:0], we[1:0]     per-port request and write enable
//   adr0/adr1             per-port address
//   wdata0/wdata1         per-port write data
//   gnt[1:0]              one-cycle one-hot grant pulse (ACCESS cycle)
//   rvalid[1:0]           one-cycle one-hot read-valid pulse (RDATA cycle)
//   rdata                 read data, valid while an rvalid bit is high
//   memRead, memWrite     registered memory strobes
//   adrToMem, dataToMem   registered memory address / write data
//   dataFromMem           memory read data, valid the cycle after memRead
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       we,
    input  logic [WIDTH-1:0] adr0,
    input  logic [WIDTH-1:0] adr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic [1:0]       gnt,
    output logic [1:0]       rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             memRead,
    output logic             memWrite,
    output logic [WIDTH-1:0] adrToMem,
    output logic [WIDTH-1:0] dataToMem,
    input  logic [WIDTH-1:0] dataFromMem
);

    state_t           state_q, state_d;
    logic             win_q, win_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic [WIDTH-1:0] adr_q, adr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             pick_win;
    logic             pick_valid;

`ifdef MEM_ARB_RR_EN
    logic             last_grant_q, last_grant_d;
`endif

    mem_arb_pick u_pick (
        .req        (req),
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .win        (pick_win),
        .win_valid  (pick_valid)
    );

    // State and output registers. Reset also clears the strobes so an
    // access in flight is simply dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            win_q        <= PORT_CPU;
            gnt_q        <= 2'b00;
            rvalid_q     <= 2'b00;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            adr_q        <= '0;
            wdata_q      <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= PORT_IO;
`endif
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            adr_q        <= adr_d;
            wdata_q      <= wdata_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Next-state logic. Pulses (gnt, rvalid, strobes) are computed one cycle
    // ahead so they come out of flops in the cycle they belong to.
    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        gnt_d        = 2'b00;
        rvalid_d     = 2'b00;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        adr_d        = adr_q;
        wdata_d      = wdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d     = ACCESS;
                    win_d       = pick_win;
                    gnt_d       = port_onehot(pick_win);
                    mem_write_d = we[pick_win];
                    mem_read_d  = ~we[pick_win];
                    adr_d       = (pick_win == PORT_IO) ? adr1 : adr0;
                    wdata_d     = (pick_win == PORT_IO) ? wdata1 : wdata0;
`ifdef MEM_ARB_RR_EN
                    last_grant_d = pick_win;
`endif
                end
            end
            ACCESS: begin
                // The registered write strobe doubles as the latched we bit.
                if (mem_write_q) begin
                    state_d = IDLE;
                end else begin
                    state_d  = RDATA;
                    rvalid_d = port_onehot(win_q);
                end
            end
            RDATA: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign memRead   = mem_read_q;
    assign memWrite  = mem_write_q;
    assign adrToMem  = adr_q;
    assign dataToMem = wdata_q;

    // Memory data passes straight through while the read result is valid.
    assign rdata = (state_q == RDATA) ? dataFromMem : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter
// Directed self-checking bench for mem_arbiter. A small synchronous memory
// sits behind the arbiter. Inputs are driven and outputs sampled on the
// falling clock edge. Expected round-robin order follows MEM_ARB_RR_EN.
// ============================================================================
module tb_mem_arbiter;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       we;
    logic [WIDTH-1:0] adr0, adr1, wdata0, wdata1;
    logic [1:0]       gnt, rvalid;
    logic [WIDTH-1:0] rdata;
    logic             memRead, memWrite;
    logic [WIDTH-1:0] adrToMem, dataToMem;
    logic [WIDTH-1:0] dataFromMem;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] mem [0:255];

    mem_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .adr0        (adr0),
        .adr1        (adr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .adrToMem    (adrToMem),
        .dataToMem   (dataToMem),
        .dataFromMem (dataFromMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous memory: write at the edge, read data one cycle later.
    always @(posedge clk) begin
        if (memWrite) mem[adrToMem[7:0]] <= dataToMem;
        if (memRead) dataFromMem <= mem[adrToMem[7:0]];
    end

    function automatic logic [1:0] oh(input int p);
        return (p == 1) ? 2'b10 : 2'b01;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt got %b want 00", gnt); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid got %b want 00", rvalid); end
        checks++; if (memRead !== 1'b0) begin errors++; $display("[TB] FAIL reset_memRead got %b want 0", memRead); end
        checks++; if (memWrite !== 1'b0) begin errors++; $display("[TB] FAIL reset_memWrite got %b want 0", memWrite); end
        checks++; if (adrToMem !== 16'h0000) begin errors++; $display("[TB] FAIL reset_adrToMem got %h want 0000", adrToMem); end
        checks++; if (dataToMem !== 16'h0000) begin errors++; $display("[TB] FAIL reset_dataToMem got %h want 0000", dataToMem); end
        reset = 1'b1;
    endtask

    task automatic test_single_write();
        req = 2'b01; we = 2'b01; adr0 = 16'h0010; wdata0 = 16'hBEEF;
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL wr_gnt got %b want 01", gnt); end
        checks++; if (memWrite !== 1'b1) begin errors++; $display("[TB] FAIL wr_memWrite got %b want 1", memWrite); end
        checks++; if (memRead !== 1'b0) begin errors++; $display("[TB] FAIL wr_memRead got %b want 0", memRead); end
        checks++; if (adrToMem !== 16'h0010) begin errors++; $display("[TB] FAIL wr_adrToMem got %h want 0010", adrToMem); end
        checks++; if (dataToMem !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_dataToMem got %h want beef", dataToMem); end
        req = 2'b00; we = 2'b00;
        step();
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL wr_idle_gnt got %b want 00", gnt); end
        checks++; if (memWrite !== 1'b0) begin errors++; $display("[TB] FAIL wr_idle_memWrite got %b want 0", memWrite); end
        checks++; if (mem[8'h10] !== 16'hBEEF) begin errors++; $display("[TB] FAIL wr_mem got %h want beef", mem[8'h10]); end
    endtask

    task automatic test_io_write();
        req = 2'b10; we = 2'b10; adr1 = 16'h0020; wdata1 = 16'h1234;
        step();
        checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL iowr_gnt got %b want 10", gnt); end
        checks++; if (memWrite !== 1'b1) begin errors++; $display("[TB] FAIL iowr_memWrite got %b want 1", memWrite); end
        checks++; if (adrToMem !== 16'h0020) begin errors++; $display("[TB] FAIL iowr_adrToMem got %h want 0020", adrToMem); end
        checks++; if (dataToMem !== 16'h1234) begin errors++; $display("[TB] FAIL iowr_dataToMem got %h want 1234", dataToMem); end
        req = 2'b00; we = 2'b00;
        step();
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL iowr_idle_gnt got %b want 00", gnt); end
    endtask

    task automatic test_single_read();
        req = 2'b10; we = 2'b00; adr1 = 16'h0010;
        step();
        checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL rd_gnt got %b want 10", gnt); end
        checks++; if (memRead !== 1'b1) begin errors++; $display("[TB] FAIL rd_memRead got %b want 1", memRead); end
        checks++; if (memWrite !== 1'b0) begin errors++; $display("[TB] FAIL rd_memWrite got %b want 0", memWrite); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rd_early_rvalid got %b want 00", rvalid); end
        req = 2'b00;
        step();
        checks++; if (rvalid !== 2'b10) begin errors++; $display("[TB] FAIL rd_rvalid got %b want 10", rvalid); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL rd_rdata got %h want beef", rdata); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rd_gnt_low got %b want 00", gnt); end
        checks++; if (memRead !== 1'b0) begin errors++; $display("[TB] FAIL rd_memRead_low got %b want 0", memRead); end
        step();
        checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rd_rvalid_low got %b want 00", rvalid); end
    endtask

    task automatic test_simultaneous();
        int g, ph, port;
        logic [WIDTH-1:0] exp_data;
        do_reset();
        req = 2'b11; we = 2'b00; adr0 = 16'h0010; adr1 = 16'h0020;
        for (int c = 1; c <= 12; c++) begin
            step();
            g  = (c - 1) / 3;
            ph = (c - 1) % 3;
`ifdef MEM_ARB_RR_EN
            port = g % 2;
`else
            port = 0;
`endif
            exp_data = (port == 1) ? 16'h1234 : 16'hBEEF;
            checks++;
            if (gnt !== ((ph == 0) ? oh(port) : 2'b00)) begin
                errors++;
                $display("[TB] FAIL sim_gnt cycle %0d got %b want %b", c, gnt, (ph == 0) ? oh(port) : 2'b00);
            end
            checks++;
            if (rvalid !== ((ph == 1) ? oh(port) : 2'b00)) begin
                errors++;
                $display("[TB] FAIL sim_rvalid cycle %0d got %b want %b", c, rvalid, (ph == 1) ? oh(port) : 2'b00);
            end
            if (ph == 1) begin
                checks++;
                if (rdata !== exp_data) begin
                    errors++;
                    $display("[TB] FAIL sim_rdata cycle %0d got %h want %h", c, rdata, exp_data);
                end
            end
        end
        req = 2'b00;
        step();
    endtask

    task automatic test_reset_in_rdata();
        req = 2'b01; we = 2'b00; adr0 = 16'h0010;
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rst_gnt got %b want 01", gnt); end
        req = 2'b00;
        step();
        checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL rst_pre_rvalid got %b want 01", rvalid); end
        reset = 1'b0;
        step();
        checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rst_rvalid got %b want 00", rvalid); end
        checks++; if (memRead !== 1'b0) begin errors++; $display("[TB] FAIL rst_memRead got %b want 0", memRead); end
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rst_gnt_low got %b want 00", gnt); end
        reset = 1'b1;
        req = 2'b11; adr1 = 16'h0020;
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rst_first_gnt got %b want 01", gnt); end
        req = 2'b00;
        repeat (2) step();
    endtask

    task automatic test_busy();
        req = 2'b01; we = 2'b00; adr0 = 16'h0010; adr1 = 16'h0020;
        step();
        checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL busy_gnt0 got %b want 01", gnt); end
        req = 2'b10;
        step();
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL busy_gnt_rdata got %b want 00", gnt); end
        checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL busy_rvalid0 got %b want 01", rvalid); end
        checks++; if (rdata !== 16'hBEEF) begin errors++; $display("[TB] FAIL busy_rdata0 got %h want beef", rdata); end
        step();
        checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL busy_gnt_idle got %b want 00", gnt); end
        step();
        checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL busy_gnt1 got %b want 10", gnt); end
        req = 2'b00;
        step();
        checks++; if (rvalid !== 2'b10) begin errors++; $display("[TB] FAIL busy_rvalid1 got %b want 10", rvalid); end
        checks++; if (rdata !== 16'h1234) begin errors++; $display("[TB] FAIL busy_rdata1 got %h want 1234", rdata); end
        step();
    endtask

    initial begin
        reset = 1'b0; req = 2'b00; we = 2'b00;
        adr0 = '0; adr1 = '0; wdata0 = '0; wdata1 = '0;
        test_reset();
        test_single_write();
        test_io_write();
        test_single_read();
        test_simultaneous();
        test_reset_in_rdata();
        test_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
